cordic_rotation_scheduler: RTL and testbench
============================================

Name: cordic_rotation_scheduler

Overview:
- Shares one pipelined CORDIC rotation core between two requesters (index 0 and 1).
- Issues at most one operation per cycle with round-robin arbitration.
- The core's mode input is global to all pipeline stages, so the scheduler holds `core_mode` constant while any operation is in flight. It drains the pipeline before switching mode.
- Tracks in-flight operations with a tag shift register and returns each result to its requester through a per-requester result FIFO with valid/ready.

Parameters:
- LATENCY, 29: cycles from core input sample to matching core output valid. One register per iteration.
- FIFO_DEPTH, 4: result FIFO entries per requester. Also the credit limit per requester. Power of two, 2..16.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 2: request valid, one bit per requester.
- `req_ready` out 2: request accepted this cycle. Asserted for at most one bit.
- `req_x` in 64: packed signed x operands, requester i at [32i+31:32i].
- `req_y` in 64: packed signed y operands.
- `req_angle` in 64: packed angle operands, same angle encoding as the core.
- `req_mode` in 4: packed 2-bit mode, requester i at [2i+1:2i]. LINEAR=00, CIRCULAR=10, HYPERBOLIC=11.
- `core_x` out 32: x to core.
- `core_y` out 32: y to core.
- `core_angle` out 32: angle to core.
- `core_mode` out 2: mode to core.
- `core_rx` in 32: core `rotated_x`.
- `core_ry` in 32: core `rotated_y`.
- `core_rangle` in 32: core `final_angle`.
- `res_valid` out 2: result FIFO non-empty, per requester.
- `res_ready` in 2: result consumed, per requester.
- `res_x` out 64: packed FIFO head x.
- `res_y` out 64: packed FIFO head y.
- `res_angle` out 64: packed FIFO head angle.

Behaviour:

Reset:
- Synchronous, takes priority over everything else.
- Clears the tag pipeline, both FIFOs and all counters.
- State goes to IDLE, `cur_mode` to 2'b10, and the round-robin pointer `fav` to 0.
- Output values under reset: `req_ready`=0, `res_valid`=0, `core_x`/`core_y`/`core_angle`=0, `core_mode`=2'b10.
- Reset mid-operation discards all in-flight results. Core pipeline contents are ignored because the tags are cleared.

Credits and eligibility:
- `credit_ok[i]` = (`inflight[i]` + `fifo_count[i]`) < FIFO_DEPTH, using registered values. A same-cycle pop is not credited.
- Requester i is eligible when `req_valid[i]` && `credit_ok[i]` && (`pipe_empty` || `req_mode[i]` == `cur_mode`).
- `pipe_empty` = no valid tag in any of the LATENCY tag stages.

Arbitration:
- Grant `fav` if eligible, otherwise grant the other requester if eligible.
- `req_ready[g]`=1 in the grant cycle. The handshake completes that cycle.
- After a grant, `fav` becomes the non-granted index.

Issue:
- In the grant cycle, `core_x`/`core_y`/`core_angle` = the selected operands, combinationally.
- `cur_mode` is loaded with `req_mode[g]` at the clock edge.
- `core_mode` = `cur_mode` when not issuing, and `req_mode[g]` when issuing from an empty pipe.
- With no grant, the core data outputs are 0.

State machine:
- IDLE: pipe empty.
  - On grant → RUN.
- RUN: operations in flight.
  - `fav` has `req_valid`, `credit_ok` and a mode different from `cur_mode` → DRAIN. No grants to the other requester from that cycle on; this prevents starvation.
  - Pipe empty and no grant → IDLE.
- DRAIN: waiting for the pipeline to empty.
  - Issue nothing until `pipe_empty`, then grant `fav` and go to RUN.
  - If `fav` drops `req_valid` while in DRAIN, return to normal arbitration: RUN, or IDLE if the pipe is empty.

Tag pipeline:
- LATENCY stages of {valid, id}. A tag enters at the edge ending the issue cycle t.
- The tag at the last stage is aligned with the core outputs during cycle t+LATENCY. `core_rx`/`core_ry`/`core_rangle` are written into FIFO[id] at that cycle's closing edge.
- Earliest `res_valid` is cycle t+LATENCY+1, i.e. LATENCY+1 cycles after the request handshake.

Counters:
- `inflight[i]` increments on issue and decrements on writeback. Both in the same cycle means no change.

FIFOs:
- First-word-fall-through. `res_*` shows the head. Pop on `res_valid[i]` && `res_ready[i]`.
- Simultaneous push and pop keeps the count.
- Overflow is impossible by credit construction.
- Results return in issue order per requester.

Optional Feature:
- Macro `CORDIC_SCHED_PERF_EN`.
- When defined: adds output `perf_drain_cycles` (32 bit), incremented every cycle the state is DRAIN. Adds output `perf_issued` (32 bit), incremented on every grant. Both saturate at all-ones and are cleared by reset.
- When undefined: neither port nor their logic exists. All other behaviour is identical.

Test Plan:
- Single op: req0 x=0x20000000, y=0, angle=0x10000000, mode=10, one cycle. Expect `req_ready`=01 in the same cycle. `res_valid[0]` exactly 30 cycles later (LATENCY=29), carrying that cycle's `core_rx`/`core_ry`/`core_rangle`. No `res_valid[1]`.
- Contention: both requesters valid every cycle, same mode 10. Expect grants alternate 01, 10, 01, ... starting with req0 after reset. Results are routed to the correct FIFO and in order.
- Mode switch: req0 mode 10 streaming, then req1 valid with mode 11 once `fav`=1. Expect state DRAIN, no grants for 29 cycles, `core_mode` held at 10 throughout. req1 is granted the cycle `pipe_empty` rises, with `core_mode`=11.
- Backpressure: `res_ready[0]`=0, req0 valid continuously. Expect exactly FIFO_DEPTH=4 grants, then `req_ready[0]`=0. A single pop frees exactly one further grant.
- Reset mid-flight: issue 3 ops, assert `reset` at cycle 10 for one cycle. Expect `res_valid`=00 and no writebacks afterward, `core_mode`=10, and `fav`=0.
- PERF build: a forced drain of 29 cycles gives `perf_drain_cycles`=29 and `perf_issued` equal to the grant count.

Source files
------------

// File: rtl/cordic_rotation_scheduler.sv
// -----------------------------------------------------------------------------
// cordic_rotation_scheduler
//
// Purpose:
//   Shares one pipelined CORDIC rotation core between two requesters. At most
//   one operation is issued per cycle, chosen round-robin. The core's mode input
//   is global to all of its stages, so the mode is held constant while anything
//   is in flight; a mode change waits until the pipeline has drained. A tag shift
//   register tracks which requester owns each in-flight slot, and each result is
//   written into that requester's first-word-fall-through result FIFO.
//
// Optional feature:
//   `define CORDIC_SCHED_PERF_EN adds the saturating performance counters
//   perf_drain_cycles (cycles spent in DRAIN) and perf_issued (grants).
//
// Ports:
//   clock, reset            single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot or zero)
//   req_x/req_y/req_angle   packed operands, requester i at [32i+31:32i]
//   req_mode                packed 2-bit mode, requester i at [2i+1:2i]
//   core_x/y/angle/mode     operands and mode presented to the core
//   core_rx/ry/rangle       core outputs, LATENCY cycles after the input sample
//   res_valid/res_ready     per-requester result handshake (FIFO non-empty / pop)
//   res_x/res_y/res_angle   packed FIFO head values
//   perf_drain_cycles, perf_issued   (only with CORDIC_SCHED_PERF_EN)
// -----------------------------------------------------------------------------
module cordic_rotation_scheduler #(
    parameter int LATENCY    = 29,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_x,
    input  logic [63:0] req_y,
    input  logic [63:0] req_angle,
    input  logic [3:0]  req_mode,
    output logic [31:0] core_x,
    output logic [31:0] core_y,
    output logic [31:0] core_angle,
    output logic [1:0]  core_mode,
    input  logic [31:0] core_rx,
    input  logic [31:0] core_ry,
    input  logic [31:0] core_rangle,
    output logic [1:0]  res_valid,
    input  logic [1:0]  res_ready,
    output logic [63:0] res_x,
    output logic [63:0] res_y,
    output logic [63:0] res_angle
`ifdef CORDIC_SCHED_PERF_EN
    ,
    output logic [31:0] perf_drain_cycles,
    output logic [31:0] perf_issued
`endif
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam int         CNT_W     = PTR_W + 1;
    localparam int         SUM_W     = CNT_W + 1;
    localparam int         ENTRY_W   = 96;
    localparam logic [1:0] MODE_CIRC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic                 fav_q, fav_d;
    logic [1:0]           cur_mode_q, cur_mode_d;
    logic [LATENCY-1:0]   tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0]   tag_id_q, tag_id_d;
    logic [CNT_W-1:0]     inflight_q [2];
    logic [CNT_W-1:0]     inflight_d [2];
    logic [CNT_W-1:0]     fifo_count_q [2];
    logic [CNT_W-1:0]     fifo_count_d [2];
    logic [PTR_W-1:0]     wr_ptr_q [2];
    logic [PTR_W-1:0]     wr_ptr_d [2];
    logic [PTR_W-1:0]     rd_ptr_q [2];
    logic [PTR_W-1:0]     rd_ptr_d [2];
    logic [ENTRY_W-1:0]   fifo_mem_q [2][FIFO_DEPTH];
    logic [ENTRY_W-1:0]   fifo_mem_d [2][FIFO_DEPTH];

    logic                 pipe_empty;
    logic [1:0]           credit_ok;
    logic [1:0]           eligible;
    logic                 other;
    logic [1:0]           fav_mode;
    logic                 drain_req;
    logic                 grant_vld;
    logic                 grant_idx;
    logic [1:0]           grant_mode;
    logic signed [31:0]   sel_x;
    logic signed [31:0]   sel_y;
    logic signed [31:0]   sel_angle;
    logic                 wb_vld;
    logic                 wb_id;
    logic [1:0]           issue;
    logic [1:0]           push;
    logic [1:0]           pop;

    // Eligibility uses registered counts only: a pop in this cycle frees its
    // credit from the next cycle on.
    always_comb begin
        pipe_empty = ~|tag_vld_q;
        credit_ok  = 2'b00;
        eligible   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            credit_ok[i] = ({1'b0, inflight_q[i]} + {1'b0, fifo_count_q[i]}) < SUM_W'(FIFO_DEPTH);
            eligible[i]  = req_valid[i] && credit_ok[i] &&
                           (pipe_empty || (req_mode[2*i +: 2] == cur_mode_q));
        end
    end

    // Arbitration and state machine.
    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        other     = ~fav_q;
        grant_idx = fav_q;
        fav_mode  = req_mode[{fav_q, 1'b0} +: 2];
        drain_req = req_valid[fav_q] && credit_ok[fav_q] && (fav_mode != cur_mode_q);

        case (state_q)
            ST_DRAIN: begin
                // Only the favoured requester may issue after a drain, which
                // keeps a same-mode stream from starving a mode change.
                if (!req_valid[fav_q]) begin
                    state_d = pipe_empty ? ST_IDLE : ST_RUN;
                end else if (pipe_empty && eligible[fav_q]) begin
                    grant_vld = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                if ((state_q == ST_RUN) && drain_req && !pipe_empty) begin
                    state_d = ST_DRAIN;
                end else begin
                    if (eligible[fav_q]) begin
                        grant_vld = 1'b1;
                    end else if (eligible[other]) begin
                        grant_vld = 1'b1;
                        grant_idx = other;
                    end
                    if (grant_vld) begin
                        state_d = ST_RUN;
                    end else if (pipe_empty) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        if (reset) begin
            grant_vld = 1'b0;
        end

        fav_d      = grant_vld ? ~grant_idx : fav_q;
        grant_mode = req_mode[{grant_idx, 1'b0} +: 2];
        cur_mode_d = grant_vld ? grant_mode : cur_mode_q;
    end

    // Issue path to the core.
    always_comb begin
        sel_x     = req_x[{grant_idx, 5'd0} +: 32];
        sel_y     = req_y[{grant_idx, 5'd0} +: 32];
        sel_angle = req_angle[{grant_idx, 5'd0} +: 32];

        req_ready = 2'b00;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end

        core_x     = grant_vld ? sel_x : '0;
        core_y     = grant_vld ? sel_y : '0;
        core_angle = grant_vld ? sel_angle : '0;
        // Issuing from a non-empty pipe implies the same mode, so the requested
        // mode can be forwarded whenever a grant is made.
        if (reset) begin
            core_mode = MODE_CIRC;
        end else begin
            core_mode = grant_vld ? grant_mode : cur_mode_q;
        end
    end

    // Result FIFO heads.
    always_comb begin
        res_valid = 2'b00;
        res_x     = '0;
        res_y     = '0;
        res_angle = '0;
        for (int i = 0; i < 2; i++) begin
            res_valid[i]        = !reset && (fifo_count_q[i] != '0);
            res_x[32*i +: 32]     = fifo_mem_q[i][rd_ptr_q[i]][31:0];
            res_y[32*i +: 32]     = fifo_mem_q[i][rd_ptr_q[i]][63:32];
            res_angle[32*i +: 32] = fifo_mem_q[i][rd_ptr_q[i]][95:64];
        end
    end

    // Tag pipeline, counters and FIFO bookkeeping. The last tag stage lines up
    // with the core outputs of the same cycle.
    always_comb begin
        wb_vld     = tag_vld_q[LATENCY-1];
        wb_id      = tag_id_q[LATENCY-1];
        tag_vld_d  = {tag_vld_q[LATENCY-2:0], grant_vld};
        tag_id_d   = {tag_id_q[LATENCY-2:0], grant_idx};
        fifo_mem_d = fifo_mem_q;
        issue      = 2'b00;
        push       = 2'b00;
        pop        = 2'b00;
        for (int i = 0; i < 2; i++) begin
            issue[i]        = grant_vld && (grant_idx == 1'(i));
            push[i]         = wb_vld && (wb_id == 1'(i));
            pop[i]          = res_valid[i] && res_ready[i];
            inflight_d[i]   = inflight_q[i] + CNT_W'(issue[i]) - CNT_W'(push[i]);
            fifo_count_d[i] = fifo_count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            wr_ptr_d[i]     = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i]     = rd_ptr_q[i] + PTR_W'(pop[i]);
            if (push[i]) begin
                fifo_mem_d[i][wr_ptr_q[i]] = {core_rangle, core_ry, core_rx};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fav_q      <= 1'b0;
            cur_mode_q <= MODE_CIRC;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                inflight_q[i]   <= '0;
                fifo_count_q[i] <= '0;
                wr_ptr_q[i]     <= '0;
                rd_ptr_q[i]     <= '0;
            end
        end else begin
            state_q    <= state_d;
            fav_q      <= fav_d;
            cur_mode_q <= cur_mode_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            for (int i = 0; i < 2; i++) begin
                inflight_q[i]   <= inflight_d[i];
                fifo_count_q[i] <= fifo_count_d[i];
                wr_ptr_q[i]     <= wr_ptr_d[i];
                rd_ptr_q[i]     <= rd_ptr_d[i];
            end
        end
    end

    // FIFO storage carries data only; pointers and counts define validity.
    always_ff @(posedge clock) begin
        fifo_mem_q <= fifo_mem_d;
    end

`ifdef CORDIC_SCHED_PERF_EN
    logic [31:0] perf_drain_q, perf_drain_d;
    logic [31:0] perf_issued_q, perf_issued_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_comb begin
        perf_drain_d  = (state_q == ST_DRAIN) ? sat_inc(perf_drain_q) : perf_drain_q;
        perf_issued_d = grant_vld ? sat_inc(perf_issued_q) : perf_issued_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_drain_q  <= '0;
            perf_issued_q <= '0;
        end else begin
            perf_drain_q  <= perf_drain_d;
            perf_issued_q <= perf_issued_d;
        end
    end

    assign perf_drain_cycles = perf_drain_q;
    assign perf_issued       = perf_issued_q;
`endif

endmodule

// File: tb/tb_cordic_rotation_scheduler.sv
module tb_cordic_rotation_scheduler;

    localparam int LAT   = 29;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_x, req_y, req_angle;
    logic [3:0]  req_mode;
    logic [31:0] core_x, core_y, core_angle;
    logic [1:0]  core_mode;
    logic [31:0] core_rx, core_ry, core_rangle;
    logic [1:0]  res_valid;
    logic [1:0]  res_ready;
    logic [63:0] res_x, res_y, res_angle;
`ifdef CORDIC_SCHED_PERF_EN
    logic [31:0] perf_drain_cycles, perf_issued;
`endif

    always #5 clock = ~clock;

    cordic_rotation_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_angle   (req_angle),
        .req_mode    (req_mode),
        .core_x      (core_x),
        .core_y      (core_y),
        .core_angle  (core_angle),
        .core_mode   (core_mode),
        .core_rx     (core_rx),
        .core_ry     (core_ry),
        .core_rangle (core_rangle),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_x       (res_x),
        .res_y       (res_y),
        .res_angle   (res_angle)
`ifdef CORDIC_SCHED_PERF_EN
        ,
        .perf_drain_cycles (perf_drain_cycles),
        .perf_issued       (perf_issued)
`endif
    );

    // Stand-in core: LAT-deep delay line with a simple, recognisable transform.
    logic [31:0] px [LAT];
    logic [31:0] py [LAT];
    logic [31:0] pa [LAT];
    logic [1:0]  pm [LAT];
    always @(posedge clock) begin
        px[0] <= core_x;
        py[0] <= core_y;
        pa[0] <= core_angle;
        pm[0] <= core_mode;
        for (int k = 1; k < LAT; k++) begin
            px[k] <= px[k-1];
            py[k] <= py[k-1];
            pa[k] <= pa[k-1];
            pm[k] <= pm[k-1];
        end
    end
    assign core_rx     = px[LAT-1] + 32'h0000_1000;
    assign core_ry     = ~py[LAT-1];
    assign core_rangle = pa[LAT-1] + {30'd0, pm[LAT-1]};

    function automatic logic [95:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] a, input logic [1:0] m);
        return {a + {30'd0, m}, ~y, x + 32'h0000_1000};
    endfunction

    int n_chk  = 0;
    int n_pass = 0;
    logic [95:0] exp_q0 [$];
    logic [95:0] exp_q1 [$];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Result scoreboard: checks every popped FIFO head against issue order.
    always begin
        @(negedge clock);
        #2;
        if (!reset) begin
            if (res_valid[0] && res_ready[0]) begin
                if (exp_q0.size() == 0) begin
                    n_chk++;
                    $display("FAIL res0_extra: got %0h, expected no result", res_x[31:0]);
                end else begin
                    chk("res0_data", {res_angle[31:0], res_y[31:0], res_x[31:0]}, exp_q0.pop_front());
                end
            end
            if (res_valid[1] && res_ready[1]) begin
                if (exp_q1.size() == 0) begin
                    n_chk++;
                    $display("FAIL res1_extra: got %0h, expected no result", res_x[63:32]);
                end else begin
                    chk("res1_data", {res_angle[63:32], res_y[63:32], res_x[63:32]}, exp_q1.pop_front());
                end
            end
        end
    end

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            reset     = 1'b1;
            req_valid = 2'b11;
            req_mode  = 4'b1111;
            req_x     = 64'h1234_5678_9abc_def0;
            req_y     = 64'h1111_2222_3333_4444;
            req_angle = 64'h5555_6666_7777_8888;
            res_ready = 2'b11;
            exp_q0.delete();
            exp_q1.delete();
        end
        #1;
    endtask

    task automatic cyc(input logic [1:0] v, input logic [3:0] m, input logic [1:0] rr,
                       input logic [31:0] seed, input logic [1:0] exp_rdy, input string nm);
        @(negedge clock);
        reset     = 1'b0;
        req_valid = v;
        req_mode  = m;
        res_ready = rr;
        req_x     = {seed ^ 32'h1111_0000, seed};
        req_y     = {seed + 32'h77, seed - 32'h33};
        req_angle = {seed << 2, seed << 1};
        #1;
        chk(nm, 96'(req_ready), 96'(exp_rdy));
        if (exp_rdy[0]) exp_q0.push_back(model(req_x[31:0], req_y[31:0], req_angle[31:0], req_mode[1:0]));
        if (exp_rdy[1]) exp_q1.push_back(model(req_x[63:32], req_y[63:32], req_angle[63:32], req_mode[3:2]));
    endtask

    task automatic drain_and_check(input string nm);
        for (int k = 0; k < 40; k++) cyc(2'b00, 4'b1010, 2'b11, 32'd0, 2'b00, nm);
        chk({nm, "_q0_empty"}, 96'(exp_q0.size()), 96'd0);
        chk({nm, "_q1_empty"}, 96'(exp_q1.size()), 96'd0);
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] exp_rdy;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic seen1;

        vecs[0] = '{2'b11, 2'b01};
        vecs[1] = '{2'b11, 2'b10};
        vecs[2] = '{2'b11, 2'b01};
        vecs[3] = '{2'b11, 2'b10};
        vecs[4] = '{2'b11, 2'b01};
        vecs[5] = '{2'b11, 2'b10};
        vecs[6] = '{2'b11, 2'b01};
        vecs[7] = '{2'b11, 2'b10};
        vecs[8] = '{2'b11, 2'b00};
        vecs[9] = '{2'b11, 2'b00};

        reset = 1'b1; req_valid = '0; req_mode = '0; res_ready = '0;
        req_x = '0; req_y = '0; req_angle = '0;

        // Reset state with requests pending.
        do_reset(2);
        chk("rst_req_ready", 96'(req_ready), 96'd0);
        chk("rst_res_valid", 96'(res_valid), 96'd0);
        chk("rst_core_mode", 96'(core_mode), 96'(2'b10));
        chk("rst_core_x", 96'(core_x), 96'd0);

        // Single operation.
        @(negedge clock);
        reset = 1'b0; req_valid = 2'b01; req_mode = 4'b0010; res_ready = 2'b00;
        req_x = {32'd0, 32'h2000_0000}; req_y = '0; req_angle = {32'd0, 32'h1000_0000};
        #1;
        chk("single_ready", 96'(req_ready), 96'(2'b01));
        chk("single_core_x", 96'(core_x), 96'(32'h2000_0000));
        chk("single_core_angle", 96'(core_angle), 96'(32'h1000_0000));
        chk("single_core_mode", 96'(core_mode), 96'(2'b10));
        exp_q0.push_back(model(32'h2000_0000, 32'd0, 32'h1000_0000, 2'b10));
        first = -1;
        seen1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            req_valid = 2'b00;
            #1;
            if (res_valid[1]) seen1 = 1'b1;
            if (res_valid[0] && first < 0) begin
                first = k;
                chk("single_rx", 96'(res_x[31:0]), 96'(32'h2000_1000));
                chk("single_ry", 96'(res_y[31:0]), 96'(32'hFFFF_FFFF));
                chk("single_rangle", 96'(res_angle[31:0]), 96'(32'h1000_0002));
            end
        end
        chk("single_latency", 96'(first), 96'd30);
        chk("single_no_res1", 96'(seen1), 96'd0);
        cyc(2'b00, 4'b1010, 2'b01, 32'd0, 2'b00, "single_pop");
        cyc(2'b00, 4'b1010, 2'b00, 32'd0, 2'b00, "single_idle");
        chk("single_popped", 96'(res_valid), 96'd0);

        // Contention: alternating grants, then credit exhaustion.
        do_reset(1);
        for (int r = 0; r < 10; r++) begin
            cyc(vecs[r].valid, 4'b1010, 2'b11, 32'h100 * (r + 1), vecs[r].exp_rdy, $sformatf("cont_v%0d", r));
        end
        drain_and_check("cont");

        // Backpressure: FIFO_DEPTH grants, then one pop frees one grant.
        do_reset(1);
        for (int k = 0; k < 4; k++) cyc(2'b01, 4'b1010, 2'b00, 32'h5000 + k, 2'b01, "bp_grant");
        for (int k = 4; k < 44; k++) cyc(2'b01, 4'b1010, 2'b00, 32'h5000 + k, 2'b00, "bp_block");
        chk("bp_full_valid", 96'(res_valid), 96'(2'b01));
        cyc(2'b01, 4'b1010, 2'b01, 32'h6000, 2'b00, "bp_pop_cycle");
        cyc(2'b01, 4'b1010, 2'b00, 32'h6001, 2'b01, "bp_regrant");
        cyc(2'b01, 4'b1010, 2'b00, 32'h6002, 2'b00, "bp_block_again");
        for (int k = 0; k < 40; k++) cyc(2'b00, 4'b1010, 2'b01, 32'd0, 2'b00, "bp_drain");
        chk("bp_q0_empty", 96'(exp_q0.size()), 96'd0);

        // Mode switch: drain 29 cycles holding mode, then switch.
        do_reset(1);
        cyc(2'b01, 4'b1110, 2'b11, 32'h7000, 2'b01, "ms_first");
        for (int k = 1; k < 30; k++) begin
            cyc(2'b11, 4'b1110, 2'b11, 32'h7000 + k, 2'b00, "ms_drain_hold");
            chk("ms_core_mode_hold", 96'(core_mode), 96'(2'b10));
        end
        cyc(2'b11, 4'b1110, 2'b11, 32'h7100, 2'b10, "ms_switch_grant");
        chk("ms_core_mode_new", 96'(core_mode), 96'(2'b11));
        cyc(2'b00, 4'b1110, 2'b11, 32'd0, 2'b00, "ms_after");
`ifdef CORDIC_SCHED_PERF_EN
        chk("perf_drain_cycles", 96'(perf_drain_cycles), 96'd29);
        chk("perf_issued", 96'(perf_issued), 96'd2);
`endif
        drain_and_check("ms");

        // Reset mid-flight discards in-flight results.
        do_reset(1);
        for (int k = 0; k < 3; k++) cyc(2'b01, 4'b1010, 2'b11, 32'h8000 + k, 2'b01, "rmf_issue");
        for (int k = 3; k < 10; k++) cyc(2'b00, 4'b1010, 2'b11, 32'd0, 2'b00, "rmf_wait");
        do_reset(1);
        chk("rmf_rst_ready", 96'(req_ready), 96'd0);
        chk("rmf_rst_valid", 96'(res_valid), 96'd0);
        chk("rmf_rst_mode", 96'(core_mode), 96'(2'b10));
        for (int k = 0; k < 40; k++) begin
            cyc(2'b00, 4'b1010, 2'b11, 32'd0, 2'b00, "rmf_idle");
            chk("rmf_no_wb", 96'(res_valid), 96'd0);
        end
        chk("rmf_core_mode", 96'(core_mode), 96'(2'b10));
        cyc(2'b11, 4'b1010, 2'b11, 32'h9000, 2'b01, "rmf_fav0");
        drain_and_check("rmf");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
